// File: rtl/seg7_bcd_display.sv
// Binary to BCD converter (shift-add-3) driving NUM_DIGITS active-low 7-segment digits.
// Build option SEG7_BLINK_EN adds the per-digit blink counter; without it blink_mask is unused.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | ready high; load captures value and starts a conversion
// S_CONV  | one shift-add-3 step per cycle for BIN_W cycles
// S_COMMIT| copy low NUM_DIGITS digits to display, latch overflow flag
module seg7_bcd_display #(
    parameter int NUM_DIGITS = 6,
    parameter int BIN_W      = 16,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [BIN_W-1:0]        value,
    output logic                    ready,
    input  logic                    blank_lz,
    input  logic [3:0]              dp_pos,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic                    ovf,
    output logic [8*NUM_DIGITS-1:0] hex_out
);

    localparam int ACC_W = 4 * (NUM_DIGITS + 1);
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_COMMIT
    } state_t;

    state_t                    state_q, state_d;
    logic [BIN_W-1:0]          bin_q, bin_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      sticky_q, sticky_d;
    logic [4*NUM_DIGITS-1:0]   bcd_q, bcd_d;
    logic                      ovf_q, ovf_d;
    logic [8*NUM_DIGITS-1:0]   hex_q, hex_d;
    logic [ACC_W-1:0]          acc_adj;
    logic [ACC_W-1:0]          acc_shift;
    logic                      phase;

    function automatic logic [7:0] seg_encode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < NUM_DIGITS + 1; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        acc_shift = {acc_adj[ACC_W-2:0], bin_q[BIN_W-1]};
    end

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    bin_d    = value;
                    acc_d    = '0;
                    cnt_d    = CNT_W'(BIN_W);
                    sticky_d = 1'b0;
                    state_d  = S_CONV;
                end
            end
            S_CONV: begin
                acc_d = acc_shift;
                bin_d = bin_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                // Once the running prefix needs the spare digit it can only grow, so
                // remember it: wide inputs can later push bits off the top entirely.
                if (acc_adj[ACC_W-1] || (acc_shift[ACC_W-1 -: 4] != 4'd0)) begin
                    sticky_d = 1'b1;
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                bcd_d   = acc_q[4*NUM_DIGITS-1:0];
                ovf_d   = sticky_q || (acc_q[ACC_W-1 -: 4] != 4'd0);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            bin_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int BC_W = $clog2(BLINK_DIV);

    logic [BC_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            phase_q, phase_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q + BC_W'(1);
        phase_d     = phase_q;
        if (blink_cnt_q == BC_W'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign phase = phase_q;
`else
    localparam int unused_blink_div = BLINK_DIV;
    logic unused_blink_mask;
    assign unused_blink_mask = ^blink_mask;
    assign phase = 1'b0;
`endif

    always_comb begin
        logic [3:0] digit;
        logic [7:0] seg;
        logic       zero_run;
        logic       dp_valid;
        hex_d    = '1;
        digit    = 4'd0;
        seg      = 8'hFF;
        zero_run = 1'b1;
        dp_valid = (int'(dp_pos) < NUM_DIGITS);
        // Walk from the most significant digit so zero_run means "this and all above are 0".
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            digit    = bcd_q[4*i +: 4];
            zero_run = zero_run && (digit == 4'd0);
            seg      = seg_encode(digit);
            if (dp_valid && (int'(dp_pos) == i)) begin
                seg[7] = 1'b0;
            end
            if (blank_lz && zero_run && (i != 0) && (!dp_valid || (i > int'(dp_pos)))) begin
                seg = 8'hFF;
            end
            if (ovf_q) begin
                seg = 8'hBF;
            end
            if (phase && blink_mask[i]) begin
                seg = 8'hFF;
            end
            hex_d[8*i +: 8] = seg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_q <= '1;
        end else begin
            hex_q <= hex_d;
        end
    end

    assign ready   = (state_q == S_IDLE);
    assign ovf     = ovf_q;
    assign hex_out = hex_q;

endmodule
